memory_board_ctrl: RTL and testbench

- Turn sequencer for the two-player memory (pairs) board built from per-tile cells.
- Owns the cursor, first/second pick, label comparison, reveal-delay timing, match/mismatch resolution, player turn, scores and game-over.
- Sits between the debounced button front-end and the tile array. Drives each tile's cursor, reveal, match and hide controls.

---
 rtl/memory_pkg.sv | 52 +++++
 rtl/memory_board_ctrl_cursor.sv | 47 ++++
 rtl/memory_board_ctrl.sv | 179 +++++++++++++++++
 tb/tb_memory_board_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// Shared types, default parameters and the forward-wrapping free-tile search
// used by the memory (pairs) board turn sequencer.
package memory_pkg;

    typedef enum logic [2:0] {
        PICK1   = 3'd0,
        PICK2   = 3'd1,
        SHOW    = 3'd2,
        RESOLVE = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int DEF_N_TILES     = 16;
    localparam int DEF_LBL_W       = 4;
    localparam int DEF_SHOW_CYCLES = 50_000_000;
    localparam int DEF_TURN_CYCLES = 500_000_000;

    // Largest board the search helper supports; narrower masks are padded
    // with blocked bits so the padding is never chosen.
    localparam int MAX_TILES  = 64;
    localparam int MASK_IDX_W = $clog2(MAX_TILES);
    localparam int MAX_IDX_W  = MASK_IDX_W + 1;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } free_t;

    // First clear bit of mask at or after start (wrapping modulo n).
    function automatic free_t next_free(input logic [MAX_TILES-1:0] mask,
                                        input int start,
                                        input int n);
        free_t                 r;
        int                    k;
        logic [MASK_IDX_W-1:0] kk;
        r.found = 1'b0;
        r.idx   = '0;
        for (int i = 0; i < MAX_TILES; i++) begin
            if (i < n && !r.found) begin
                k = start + i;
                if (k >= n) k = k - n;
                kk = MASK_IDX_W'(k);
                if (!mask[kk]) begin
                    r.found = 1'b1;
                    r.idx   = MAX_IDX_W'(k);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/memory_board_ctrl_cursor.sv
// Cursor register for the pairs board. It steps to the next non-blocked tile
// after the current one, or realigns to the first non-blocked tile at or after
// the current one. When every tile is blocked the cursor holds.
module memory_cursor
    import memory_pkg::*;
#(
    parameter int N_TILES = DEF_N_TILES,
    parameter int IDX_W   = $clog2(N_TILES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               step,
    input  logic               align,
    input  logic [N_TILES-1:0] blocked,
    output logic [IDX_W-1:0]   cursor
);

    logic [MAX_TILES-1:0] blocked_ext;
    int                   step_start;
    free_t                step_res;
    free_t                align_res;
    logic                 step_ok;
    logic                 align_ok;

    // Search candidates for both a forward step and an at-or-after realign.
    always_comb begin
        blocked_ext                = '1;
        blocked_ext[N_TILES-1:0]   = blocked;
        step_start = (int'(cursor) + 1 >= N_TILES) ? 0 : int'(cursor) + 1;
        step_res   = next_free(blocked_ext, step_start, N_TILES);
        align_res  = next_free(blocked_ext, int'(cursor), N_TILES);
        step_ok    = step_res.found  && (step_res.idx  < MAX_IDX_W'(N_TILES));
        align_ok   = align_res.found && (align_res.idx < MAX_IDX_W'(N_TILES));
    end

    // Cursor register; realign takes precedence over a step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cursor <= '0;
        end else if (align && align_ok) begin
            cursor <= align_res.idx[IDX_W-1:0];
        end else if (step && step_ok) begin
            cursor <= step_res.idx[IDX_W-1:0];
        end
    end

endmodule

// File: rtl/memory_board_ctrl.sv
// Turn sequencer for the two-player pairs board: picks, reveal timing,
// match/mismatch resolution, turn timeout, scores and game-over.
module memory_board_ctrl
    import memory_pkg::*;
#(
    parameter int N_TILES     = DEF_N_TILES,
    parameter int LBL_W       = DEF_LBL_W,
    parameter int SHOW_CYCLES = DEF_SHOW_CYCLES,
    parameter int TURN_CYCLES = DEF_TURN_CYCLES,
    parameter int IDX_W       = $clog2(N_TILES)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     btn_move,
    input  logic                     btn_select,
    input  logic [N_TILES*LBL_W-1:0] labels_i,
    output logic [IDX_W-1:0]         cursor_o,
    output logic [N_TILES-1:0]       reveal_o,
    output logic [N_TILES-1:0]       matched_o,
    output logic [N_TILES-1:0]       owner_o,
    output logic                     hide_o,
    output logic                     player_o,
    output logic [IDX_W-1:0]         score0_o,
    output logic [IDX_W-1:0]         score1_o,
    output logic                     game_over_o
);

    localparam int SHOW_W = $clog2(SHOW_CYCLES + 1);
    localparam int TURN_W = $clog2(TURN_CYCLES + 1);
    localparam logic [SHOW_W-1:0]  SHOW_LOAD = SHOW_W'(SHOW_CYCLES - 1);
    // Turn time is tracked as elapsed cycles so that a reset value of zero
    // already means "fresh turn"; reaching TURN_LAST is the expiry point.
    localparam logic [TURN_W-1:0]  TURN_LAST = TURN_W'(TURN_CYCLES - 1);
    localparam logic [IDX_W-1:0]   SCORE_MAX = IDX_W'(N_TILES / 2);
    localparam logic [N_TILES-1:0] ONE       = N_TILES'(1);

    state_t              state;
    logic [IDX_W-1:0]    first;
    logic [IDX_W-1:0]    second;
    logic [SHOW_W-1:0]   show_cnt;
    logic [TURN_W-1:0]   turn_cnt;

    logic [N_TILES-1:0]  cur_bit;
    logic [N_TILES-1:0]  pair_bits;
    logic [N_TILES-1:0]  matched_win;
    logic [N_TILES-1:0]  cur_blocked;
    logic [LBL_W-1:0]    lbl_first;
    logic [LBL_W-1:0]    lbl_second;
    logic                labels_eq;
    logic                turn_expired;
    logic                sel1_ok;
    logic                sel2_ok;
    logic                cur_step;
    logic                cur_align;

    // Decode pick acceptance, label comparison and cursor control.
    always_comb begin
        lbl_first  = '0;
        lbl_second = '0;
        for (int k = 0; k < N_TILES; k++) begin
            if (IDX_W'(k) == first)  lbl_first  = labels_i[k*LBL_W +: LBL_W];
            if (IDX_W'(k) == second) lbl_second = labels_i[k*LBL_W +: LBL_W];
        end
        cur_bit      = ONE << cursor_o;
        pair_bits    = (ONE << first) | (ONE << second);
        matched_win  = matched_o | pair_bits;
        labels_eq    = (lbl_first == lbl_second);
        turn_expired = (turn_cnt == TURN_LAST);
        sel1_ok      = (state == PICK1) && btn_select && !matched_o[cursor_o];
        sel2_ok      = (state == PICK2) && btn_select && !matched_o[cursor_o]
                       && (cursor_o != first);
        // A select (accepted or not) always drops a simultaneous move.
        cur_step     = sel1_ok || (((state == PICK1) || (state == PICK2))
                                   && btn_move && !btn_select);
        cur_align    = (state == RESOLVE);
        if (state == RESOLVE) begin
            cur_blocked = labels_eq ? matched_win : matched_o;
        end else begin
            cur_blocked = matched_o | reveal_o | (sel1_ok ? cur_bit : '0);
        end
    end

    memory_cursor #(
        .N_TILES (N_TILES),
        .IDX_W   (IDX_W)
    ) u_cursor (
        .clk     (clk),
        .rst     (rst),
        .step    (cur_step),
        .align   (cur_align),
        .blocked (cur_blocked),
        .cursor  (cursor_o)
    );

    // Turn FSM with timers, scores and all registered board outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= PICK1;
            first       <= '0;
            second      <= '0;
            show_cnt    <= '0;
            turn_cnt    <= '0;
            reveal_o    <= '0;
            matched_o   <= '0;
            owner_o     <= '0;
            hide_o      <= 1'b0;
            player_o    <= 1'b0;
            score0_o    <= '0;
            score1_o    <= '0;
            game_over_o <= 1'b0;
        end else begin
            hide_o <= 1'b0;
            case (state)
                PICK1: begin
                    if (sel1_ok) begin
                        first    <= cursor_o;
                        reveal_o <= reveal_o | cur_bit;
                        state    <= PICK2;
                        if (!turn_expired) turn_cnt <= turn_cnt + 1'b1;
                    end else if (turn_expired) begin
                        player_o <= ~player_o;
                        turn_cnt <= '0;
                    end else begin
                        turn_cnt <= turn_cnt + 1'b1;
                    end
                end
                PICK2: begin
                    if (sel2_ok) begin
                        second   <= cursor_o;
                        reveal_o <= reveal_o | cur_bit;
                        show_cnt <= SHOW_LOAD;
                        state    <= SHOW;
                    end else if (turn_expired) begin
                        reveal_o <= '0;
                        hide_o   <= 1'b1;
                        player_o <= ~player_o;
                        turn_cnt <= '0;
                        state    <= PICK1;
                    end else begin
                        turn_cnt <= turn_cnt + 1'b1;
                    end
                end
                SHOW: begin
                    if (show_cnt == '0) state <= RESOLVE;
                    else                show_cnt <= show_cnt - 1'b1;
                end
                RESOLVE: begin
                    reveal_o <= '0;
                    turn_cnt <= '0;
                    if (labels_eq) begin
                        matched_o <= matched_win;
                        owner_o   <= player_o ? (owner_o | pair_bits)
                                              : (owner_o & ~pair_bits);
                        if (!player_o) begin
                            if (score0_o != SCORE_MAX) score0_o <= score0_o + 1'b1;
                        end else begin
                            if (score1_o != SCORE_MAX) score1_o <= score1_o + 1'b1;
                        end
                        if (&matched_win) begin
                            state       <= DONE;
                            game_over_o <= 1'b1;
                        end else begin
                            state <= PICK1;
                        end
                    end else begin
                        hide_o   <= 1'b1;
                        player_o <= ~player_o;
                        state    <= PICK1;
                    end
                end
                DONE: begin
                    game_over_o <= 1'b1;
                end
                default: state <= PICK1;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_board_ctrl.sv
// Directed bench for memory_board_ctrl: a 16-tile board for cursor, match,
// mismatch and skip behaviour, and a 4-tile board with a short turn limit for
// timeout and a full game.
module tb_memory_board_ctrl;

    localparam int NA   = 16;
    localparam int NG   = 4;
    localparam int LW   = 4;
    localparam int IA   = 4;
    localparam int IG   = 2;
    localparam int SB_W = 2 + 2*IA + NA;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_a, move_a, sel_a;
    logic [NA*LW-1:0]  labels_a;
    logic [IA-1:0]     cursor_a, score0_a, score1_a;
    logic [NA-1:0]     reveal_a, matched_a, owner_a;
    logic              hide_a, player_a, over_a;

    logic              rst_g, move_g, sel_g;
    logic [NG*LW-1:0]  labels_g;
    logic [IG-1:0]     cursor_g, score0_g, score1_g;
    logic [NG-1:0]     reveal_g, matched_g, owner_g;
    logic              hide_g, player_g, over_g;

    int total = 0;
    int bad   = 0;
    int hide_cnt_a = 0;
    int hide_base;
    logic [SB_W-1:0] exp_q[$];
    logic [SB_W-1:0] sb_exp;
    logic [SB_W-1:0] sb_obs;
    logic [NA-1:0]   prev_reveal_a = '0;

    memory_board_ctrl #(
        .N_TILES(NA), .LBL_W(LW), .SHOW_CYCLES(4), .TURN_CYCLES(1000)
    ) u_dut_a (
        .clk(clk), .rst(rst_a), .btn_move(move_a), .btn_select(sel_a),
        .labels_i(labels_a), .cursor_o(cursor_a), .reveal_o(reveal_a),
        .matched_o(matched_a), .owner_o(owner_a), .hide_o(hide_a),
        .player_o(player_a), .score0_o(score0_a), .score1_o(score1_a),
        .game_over_o(over_a)
    );

    memory_board_ctrl #(
        .N_TILES(NG), .LBL_W(LW), .SHOW_CYCLES(4), .TURN_CYCLES(8)
    ) u_dut_g (
        .clk(clk), .rst(rst_g), .btn_move(move_g), .btn_select(sel_g),
        .labels_i(labels_g), .cursor_o(cursor_g), .reveal_o(reveal_g),
        .matched_o(matched_g), .owner_o(owner_g), .hide_o(hide_g),
        .player_o(player_g), .score0_o(score0_g), .score1_o(score1_g),
        .game_over_o(over_g)
    );

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_move_a();
        move_a = 1'b1; tick(); move_a = 1'b0;
    endtask

    task automatic pulse_sel_a();
        sel_a = 1'b1; tick(); sel_a = 1'b0;
    endtask

    task automatic pulse_move_g();
        move_g = 1'b1; tick(); move_g = 1'b0;
    endtask

    task automatic pulse_sel_g();
        sel_g = 1'b1; tick(); sel_g = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [SB_W-1:0] sb(input logic h, input logic p,
                                           input logic [IA-1:0] s0, input logic [IA-1:0] s1,
                                           input logic [NA-1:0] m);
        return {h, p, s0, s1, m};
    endfunction

    // scoreboard: every end of a reveal on board A is a resolution event
    always @(negedge clk) begin
        if (rst_a === 1'b1) begin
            if (hide_a === 1'b1) hide_cnt_a++;
            if (prev_reveal_a != '0 && reveal_a == '0) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $error("FAIL sb_unexpected observed=resolution expected=none");
                end else begin
                    sb_exp = exp_q.pop_front();
                    sb_obs = {hide_a, player_a, score0_a, score1_a, matched_a};
                    assert (sb_obs === sb_exp) else begin
                        bad++;
                        $error("FAIL sb_resolve observed=%h expected=%h", sb_obs, sb_exp);
                    end
                end
            end
            prev_reveal_a = reveal_a;
        end
    end

    initial begin
        rst_a = 1'b0; move_a = 1'b0; sel_a = 1'b0;
        rst_g = 1'b0; move_g = 1'b0; sel_g = 1'b0;
        for (int k = 0; k < NA; k++) labels_a[k*LW +: LW] = 4'hF;
        labels_a[0*LW +: LW] = 4'd5;
        labels_a[1*LW +: LW] = 4'd5;
        labels_a[2*LW +: LW] = 4'd3;
        labels_a[3*LW +: LW] = 4'd7;
        labels_a[4*LW +: LW] = 4'd9;
        labels_a[5*LW +: LW] = 4'd9;
        labels_g = {4'd6, 4'd6, 4'd2, 4'd2};

        repeat (3) @(posedge clk);
        #1 rst_a = 1'b1;

        // reset state
        check("rst_cursor",  cursor_a,  0);
        check("rst_reveal",  reveal_a,  0);
        check("rst_matched", matched_a, 0);
        check("rst_player",  player_a,  0);
        check("rst_scores",  {score0_a, score1_a}, 0);
        check("rst_over",    over_a,    0);

        // plain cursor movement
        repeat (3) pulse_move_a();
        check("move3_cursor", cursor_a, 3);
        check("move3_player", player_a, 0);
        check("move3_score0", score0_a, 0);
        check("move3_reveal", reveal_a, 0);
        repeat (13) pulse_move_a();
        check("wrap_cursor", cursor_a, 0);

        // matching pair 0/1 by player 0
        pulse_sel_a();
        check("pick1_reveal", reveal_a, 16'h0001);
        check("pick1_cursor", cursor_a, 1);
        exp_q.push_back(sb(1'b0, 1'b0, 4'd1, 4'd0, 16'h0003));
        pulse_sel_a();
        for (int i = 0; i < 4; i++) begin
            check("show_reveal", reveal_a, 16'h0003);
            tick();
        end
        for (int i = 0; i < 10 && matched_a != 16'h0003; i++) tick();
        check("match_matched", matched_a, 16'h0003);
        check("match_reveal",  reveal_a,  0);
        check("match_owner",   owner_a,   0);
        check("match_player",  player_a,  0);
        check("match_hide",    hide_a,    0);
        check("match_cursor",  cursor_a,  2);

        // mismatching pair 2/3 by player 0
        pulse_sel_a();
        check("mm_pick1_reveal", reveal_a, 16'h0004);
        check("mm_pick1_cursor", cursor_a, 3);
        exp_q.push_back(sb(1'b1, 1'b1, 4'd1, 4'd0, 16'h0003));
        hide_base = hide_cnt_a;
        pulse_sel_a();
        check("mm_pick2_reveal", reveal_a, 16'h000C);
        for (int i = 0; i < 10 && reveal_a != '0; i++) tick();
        check("mm_reveal", reveal_a, 0);
        check("mm_hide",   hide_a,   1);
        check("mm_player", player_a, 1);
        check("mm_scores", {score0_a, score1_a}, 8'h10);
        tick();
        check("mm_hide_end", hide_a, 0);
        tick();
        check("mm_hide_count", hide_cnt_a - hide_base, 1);
        check("mm_cursor", cursor_a, 3);

        // skip over matched tiles on wrap
        repeat (12) pulse_move_a();
        check("skip_pre_cursor", cursor_a, 15);
        pulse_move_a();
        check("skip_cursor", cursor_a, 2);

        // player 1 matches 4/5; buttons during SHOW are ignored
        repeat (2) pulse_move_a();
        check("p1_cursor", cursor_a, 4);
        pulse_sel_a();
        check("p1_pick1_reveal", reveal_a, 16'h0010);
        check("p1_pick1_cursor", cursor_a, 5);
        exp_q.push_back(sb(1'b0, 1'b1, 4'd1, 4'd1, 16'h0033));
        pulse_sel_a();
        move_a = 1'b1; sel_a = 1'b1;
        tick();
        move_a = 1'b0; sel_a = 1'b0;
        check("show_ign_cursor", cursor_a, 5);
        check("show_ign_reveal", reveal_a, 16'h0030);
        for (int i = 0; i < 10 && matched_a != 16'h0033; i++) tick();
        check("p1_matched", matched_a, 16'h0033);
        check("p1_owner",   owner_a,   16'h0030);
        check("p1_score1",  score1_a,  1);
        check("p1_player",  player_a,  1);
        check("p1_cursor_after", cursor_a, 6);
        check("p1_over",    over_a,    0);

        // timeout on the 4-tile board (turn limit 8 cycles)
        @(posedge clk);
        #1 rst_g = 1'b1;
        pulse_sel_g();
        check("to_pick_reveal", reveal_g, 4'h1);
        check("to_pick_cursor", cursor_g, 1);
        repeat (6) tick();
        check("to_pre_reveal", reveal_g, 4'h1);
        check("to_pre_hide",   hide_g,   0);
        check("to_pre_player", player_g, 0);
        tick();
        check("to_hide",   hide_g,   1);
        check("to_reveal", reveal_g, 0);
        check("to_player", player_g, 1);
        pulse_sel_g();
        check("to2_hide_end", hide_g,   0);
        check("to2_reveal",   reveal_g, 4'h2);
        check("to2_cursor",   cursor_g, 2);
        repeat (6) tick();
        pulse_sel_g();
        check("to2_sel_player", player_g, 1);
        check("to2_sel_hide",   hide_g,   0);
        check("to2_sel_reveal", reveal_g, 4'h6);
        repeat (5) tick();
        check("to2_res_hide",    hide_g,    1);
        check("to2_res_player",  player_g,  0);
        check("to2_res_reveal",  reveal_g,  0);
        check("to2_res_matched", matched_g, 0);
        check("to2_res_cursor",  cursor_g,  2);

        // asynchronous reset, then a full game by player 0
        #2 rst_g = 1'b0;
        #1;
        check("arst_cursor", cursor_g, 0);
        rst_g = 1'b1;
        pulse_sel_g();
        pulse_sel_g();
        for (int i = 0; i < 10 && matched_g != 4'h3; i++) tick();
        check("g1_matched", matched_g, 4'h3);
        check("g1_score0",  score0_g,  1);
        check("g1_player",  player_g,  0);
        check("g1_cursor",  cursor_g,  2);
        pulse_sel_g();
        pulse_sel_g();
        for (int i = 0; i < 12 && over_g != 1'b1; i++) tick();
        check("g2_over",    over_g,    1);
        check("g2_matched", matched_g, 4'hF);
        check("g2_scores",  {score0_g, score1_g}, 4'h8);
        check("g2_owner",   owner_g,   0);
        check("g2_player",  player_g,  0);
        check("g2_reveal",  reveal_g,  0);
        check("g2_cursor",  cursor_g,  3);
        pulse_move_g();
        pulse_sel_g();
        repeat (12) tick();
        check("done_ign_cursor", cursor_g, 3);
        check("done_ign_over",   over_g,   1);
        check("done_ign_score0", score0_g, 2);
        check("done_ign_player", player_g, 0);
        check("done_ign_hide",   hide_g,   0);
        #3 rst_g = 1'b0;
        #1;
        check("arst2_over",    over_g,    0);
        check("arst2_matched", matched_g, 0);
        check("arst2_score0",  score0_g,  0);
        check("arst2_cursor",  cursor_g,  0);
        check("arst2_owner",   owner_g,   0);
        rst_g = 1'b1;

        tick();
        check("sb_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
